mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencing controller that shares the single-ported, multi-cycle unified memory between the instruction-fetch port and the data-memory port of the processor. The data port is driven by the decoder's MemEnable/MemWr outputs. The block issues one memory transaction at a time and returns read data to the winning requester. It drives per-port stall signals that freeze the pipeline until that port's access completes.

## Interface
- STARVE_LIMIT, 4: consecutive DM grants allowed while a fetch is waiting; the next grant is forced to IF.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  16  fetch address; stable while if_req is high.
- dm_req  in  1  data request (MemEnable); held high until dm_done.
- dm_wr  in  1  1 = store, 0 = load (MemWr); stable with dm_req.
- dm_addr  in  16  data address.
- dm_wdata  in  16  store data.
- halt  in  1  blocks new fetch grants; an in-flight fetch still completes.
- mem_busy  in  1  memory cannot accept an issue this cycle.
- mem_done  in  1  one-cycle pulse; the issued transaction is complete.
- mem_rdata  in  16  read data; valid when mem_done = 1.
- mem_en  out  1  registered one-cycle issue pulse.
- mem_wr  out  1  write qualifier; valid with mem_en.
- mem_addr  out  16  issue address; valid with mem_en.
- mem_wdata  out  16  issue write data; valid with mem_en.
- if_done, dm_done  out  1  registered one-cycle completion pulse per port.
- if_rdata, dm_rdata  out  16  registered read data; held until the next load on that port.
- if_stall, dm_stall  out  1  combinational: if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. A 1-bit owner register records the winner (IF or DM).
- IDLE: requests are sampled only in this state.
  - If mem_busy = 1, or neither dm_req nor eligible IF (if_req & ~halt) is present, stay in IDLE.
  - Otherwise select a winner and go to ISSUE.
- Priority: DM wins by default.
  - IF wins when DM is not requesting.
  - IF also wins when starve_cnt == STARVE_LIMIT and IF is eligible.
- ISSUE: drive mem_en = 1 with the owner's fields for exactly one cycle, then go to WAIT.
  - IF issues always have mem_wr = 0 and mem_wdata = 0.
- WAIT: wait for mem_done. On mem_done, latch mem_rdata into the owner's rdata, but only for IF or a DM load (DM store leaves dm_rdata unchanged). Then go to RESP.
- RESP: pulse the owner's done for one cycle, then go to IDLE.
  - A requester may keep req high after done to request back-to-back; the request is sampled in the following IDLE cycle.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating, on each DM grant while IF is eligible.
  - Clears on an IF grant.
  - Clears in any IDLE cycle with if_req = 0.
- mem_done outside WAIT is ignored. This covers a stale completion from before reset.
- halt only gates IF eligibility. DM requests continue to be served while halted.
- Reset (from any state, including mid-transaction):
  - state = IDLE, starve_cnt = 0.
  - mem_en, mem_wr, if_done, dm_done = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - The interrupted requester re-requests after reset.

## Timing
- Memory latency L is the number of cycles from mem_en to mem_done (L ≥ 1).
- Request seen in IDLE at cycle 0 with mem_busy = 0:
  - mem_en at cycle 1.
  - mem_done at cycle 1+L.
  - done and rdata at cycle 2+L.
- Total request-to-done latency is L+2. The earliest re-issue is 2 cycles after done (cycle 4+L).
- Simultaneous if_req and dm_req in IDLE: DM is served unless the starvation limit has been reached. The loser stays stalled.
- The stall outputs fall in the same cycle as done; the pipeline advances on the next edge.

## Test plan
- Single IF read at 0x0040, L = 2, mem_rdata = 0x1234 → mem_en at cycle 1 with addr 0x0040 and mem_wr = 0; if_done and if_rdata = 0x1234 at cycle 4; if_stall high during cycles 0–3.
- DM store of 0xBEEF to 0x0100 together with a pending IF → the store issues first (mem_wr = 1, mem_wdata = 0xBEEF); dm_rdata unchanged; the IF issues 2 cycles after dm_done.
- dm_req and if_req held continuously, STARVE_LIMIT = 4 → grant order DM, DM, DM, DM, IF, then repeating.
- halt = 1 with if_req held → no IF issue occurs and if_stall stays 1; halt asserted during a WAIT on a fetch still lets that fetch complete with if_done.
- mem_busy = 1 for 3 cycles with dm_req high → no mem_en until the cycle after mem_busy falls.
- rst pulsed during WAIT, followed by a stray mem_done → all outputs return to 0, the stray mem_done is ignored, and no done pulse is generated.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-ported, multi-cycle unified memory between the
//   instruction-fetch (IF) port and the data-memory (DM) port. Only one memory
//   transaction is in flight at a time. Read data goes back to the port that
//   won the grant, and each port gets a stall signal that holds the pipeline
//   until that port's access completes.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   if_req, if_addr       fetch request/address (request held until if_done)
//   dm_req, dm_wr,        data request (MemEnable), 1 = store (MemWr),
//   dm_addr, dm_wdata     address and store data
//   halt                  blocks new fetch grants (an in-flight fetch finishes)
//   mem_busy              memory cannot accept an issue this cycle
//   mem_done, mem_rdata   completion pulse and read data from memory
//   mem_en, mem_wr,       registered one-cycle issue pulse with its
//   mem_addr, mem_wdata   write qualifier, address and write data
//   if_done, dm_done      registered one-cycle completion pulse per port
//   if_rdata, dm_rdata    registered read data, held until the next load
//   if_stall, dm_stall    combinational: req & ~done
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic        halt,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        if_done,
  output logic        dm_done,
  output logic [15:0] if_rdata,
  output logic [15:0] dm_rdata,
  output logic        if_stall,
  output logic        dm_stall
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner_dm;
  logic          owner_wr;
  logic [CW-1:0] starve_cnt;
  logic          if_elig;
  logic          grant;
  logic          grant_dm;

  assign if_elig  = if_req & ~halt;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // Next state and grant decision. Requests are only looked at in IDLE; DM
  // wins unless a waiting fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dm  = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_busy && (dm_req || if_elig)) begin
          grant     = 1'b1;
          grant_dm  = dm_req && !(if_elig && (starve_cnt == CW'(STARVE_LIMIT)));
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      owner_wr   <= 1'b0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state   <= state_nxt;
      mem_en  <= grant;
      mem_wr  <= grant & grant_dm & dm_wr;
      if_done <= 1'b0;
      dm_done <= 1'b0;

      if (grant) begin
        owner_dm  <= grant_dm;
        owner_wr  <= grant_dm & dm_wr;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : 16'h0000;
      end

      // Starvation counter only moves in IDLE; a DM grant counts against a
      // fetch only if that fetch could actually have been granted.
      if (state == IDLE) begin
        if (grant && !grant_dm) begin
          starve_cnt <= '0;
        end else if (grant && if_elig) begin
          if (starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CW'(1);
        end else if (!if_req) begin
          starve_cnt <= '0;
        end
      end

      // mem_done is honoured only while waiting, so stale completions vanish.
      // A store completes without touching dm_rdata.
      if (state == WAIT && mem_done) begin
        if (owner_dm) begin
          dm_done <= 1'b1;
          if (!owner_wr) dm_rdata <= mem_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A behavioural memory answers each
//   issue after memLat cycles; expected issues and per-port read data are
//   queued when stimulus is driven and compared when the DUT produces them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        halt;
  logic        mem_busy;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        if_done;
  logic        dm_done;
  logic [15:0] if_rdata;
  logic [15:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .halt(halt), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_done(if_done), .dm_done(dm_done), .if_rdata(if_rdata), .dm_rdata(dm_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } issue_t;

  typedef struct {
    string       name;
    bit          isDm;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] expRdata;
  } vec_t;

  issue_t      issueQ[$];
  logic [15:0] ifRespQ[$];
  logic [15:0] dmRespQ[$];

  int          compared = 0;
  int          mismatched = 0;
  int          cycleCnt = 0;
  int          memLat = 1;
  int          memCnt = 0;
  logic [15:0] issAddr = 16'h0;
  int          lastIssueCycle = -1;
  int          issueCount = 0;
  logic        prevEn = 1'b0;
  int          ifDoneCount = 0;
  int          dmDoneCount = 0;
  logic [15:0] dmModel = 16'h0;
  vec_t        vecs[6];

  function automatic logic [15:0] rdataFor(input logic [15:0] a);
    if (a == 16'h0040) return 16'h1234;
    return a ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural memory: sees the issue pulse mid-cycle and answers memLat
  // cycles later with a one-cycle mem_done. Ignores rst so a stale completion
  // can land after a reset.
  always @(negedge clk) begin
    issue_t exp;
    mem_done  = 1'b0;
    mem_rdata = 16'hDEAD;
    if (memCnt > 0) begin
      memCnt--;
      if (memCnt == 0) begin
        mem_done  = 1'b1;
        mem_rdata = rdataFor(issAddr);
      end
    end
    if (mem_en === 1'b1) begin
      checkOutput("issue_pulse_width", 32'(prevEn), 32'd0);
      issueCount++;
      lastIssueCycle = cycleCnt;
      checkOutput("issue_expected", 32'(issueQ.size() != 0), 32'd1);
      if (issueQ.size() != 0) begin
        exp = issueQ.pop_front();
        checkOutput("issue_wr", 32'(mem_wr), 32'(exp.wr));
        checkOutput("issue_addr", 32'(mem_addr), 32'(exp.addr));
        checkOutput("issue_wdata", 32'(mem_wdata), 32'(exp.wdata));
      end
      memCnt  = memLat;
      issAddr = mem_addr;
    end
    prevEn = mem_en;
  end

  // Response scoreboard: every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (if_done === 1'b1) begin
      ifDoneCount++;
      checkOutput("if_done_expected", 32'(ifRespQ.size() != 0), 32'd1);
      if (ifRespQ.size() != 0) checkOutput("if_rdata", 32'(if_rdata), 32'(ifRespQ.pop_front()));
    end
    if (dm_done === 1'b1) begin
      dmDoneCount++;
      checkOutput("dm_done_expected", 32'(dmRespQ.size() != 0), 32'd1);
      if (dmRespQ.size() != 0) checkOutput("dm_rdata", 32'(dm_rdata), 32'(dmRespQ.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One isolated transaction from the vector table: checks issue timing,
  // request-to-done latency and the stall profile.
  task automatic applyStimulus(input vec_t v);
    int reqCycle;
    int cyc;
    bit seen;
    memLat = v.lat;
    @(negedge clk);
    issueQ.push_back('{v.isDm ? v.wr : 1'b0, v.addr, v.isDm ? v.wdata : 16'h0});
    if (v.isDm) begin
      dmRespQ.push_back(v.expRdata);
      dmModel  = v.expRdata;
      dm_req   = 1'b1;
      dm_wr    = v.wr;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
    end else begin
      ifRespQ.push_back(v.expRdata);
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    reqCycle = cycleCnt;
    #1;
    checkOutput({v.name, "_stall_c0"}, 32'(v.isDm ? dm_stall : if_stall), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if ((v.isDm ? dm_done : if_done) === 1'b1) seen = 1'b1;
      else checkOutput({v.name, "_stall"}, 32'(v.isDm ? dm_stall : if_stall), 32'd1);
    end
    checkOutput({v.name, "_latency"}, 32'(cyc), 32'(v.lat + 2));
    checkOutput({v.name, "_stall_at_done"}, 32'(v.isDm ? dm_stall : if_stall), 32'd0);
    checkOutput({v.name, "_issue_delay"}, 32'(lastIssueCycle - reqCycle), 32'd1);
    if (v.isDm) begin
      dm_req = 1'b0;
      dm_wr  = 1'b0;
    end else begin
      if_req = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int ifSeen;
    int dmSeen;
    int dmDoneCyc;
    int startIssues;
    int startDones;
    int fallCycle;
    bit seen;

    vecs[0] = '{"if_read_0040",   1'b0, 1'b0, 16'h0040, 16'h0000, 2, 16'h1234};
    vecs[1] = '{"dm_load_0100",   1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h5B3C};
    vecs[2] = '{"dm_store_0100",  1'b1, 1'b1, 16'h0100, 16'h1357, 3, 16'h5B3C};
    vecs[3] = '{"if_read_1ffe",   1'b0, 1'b0, 16'h1FFE, 16'h0000, 4, 16'h45C2};
    vecs[4] = '{"dm_load_ffff",   1'b1, 1'b0, 16'hFFFF, 16'h0000, 1, 16'hA5C3};
    vecs[5] = '{"if_read_0000",   1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h5A3C};

    rst = 1'b1; if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_addr = 16'h0; dm_wdata = 16'hCAFE; halt = 1'b0; mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_if_done", 32'(if_done), 32'd0);
    checkOutput("reset_dm_done", 32'(dm_done), 32'd0);
    checkOutput("reset_if_rdata", 32'(if_rdata), 32'd0);
    checkOutput("reset_dm_rdata", 32'(dm_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table-driven single transactions");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] DM store racing a pending fetch");
    @(negedge clk);
    memLat = 2;
    issueQ.push_back('{1'b1, 16'h0100, 16'hBEEF});
    issueQ.push_back('{1'b0, 16'h0040, 16'h0000});
    dmRespQ.push_back(dmModel);
    ifRespQ.push_back(16'h1234);
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
    if_req = 1'b1; if_addr = 16'h0040;
    cyc = 0; seen = 1'b0; dmDoneCyc = -100;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (dm_done === 1'b1) begin
        dmDoneCyc = cycleCnt;
        dm_req = 1'b0; dm_wr = 1'b0;
      end
      if (if_done === 1'b1) begin
        seen = 1'b1;
        if_req = 1'b0;
      end
    end
    checkOutput("storeif_if_done_seen", 32'(seen), 32'd1);
    checkOutput("storeif_if_issue_gap", 32'(lastIssueCycle - dmDoneCyc), 32'd2);
    checkOutput("storeif_dm_rdata_kept", 32'(dm_rdata), 32'(dmModel));

    $display("[TB] starvation: both ports requesting continuously");
    @(negedge clk);
    memLat = 1;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) begin
        issueQ.push_back('{1'b0, 16'h2000, 16'h0000});
        ifRespQ.push_back(rdataFor(16'h2000));
      end else begin
        issueQ.push_back('{1'b0, 16'h3000, 16'h0000});
        dmRespQ.push_back(rdataFor(16'h3000));
      end
    end
    dmModel = rdataFor(16'h3000);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h3000; dm_wdata = 16'h0;
    if_req = 1'b1; if_addr = 16'h2000;
    cyc = 0; ifSeen = 0; dmSeen = 0;
    while (ifSeen < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dm_done === 1'b1) dmSeen++;
      if (if_done === 1'b1) ifSeen++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    checkOutput("starve_if_grants", 32'(ifSeen), 32'd2);
    checkOutput("starve_dm_grants", 32'(dmSeen), 32'd8);
    checkOutput("starve_queue_drained", 32'(issueQ.size()), 32'd0);

    $display("[TB] halt blocks fetch but not data accesses");
    @(negedge clk);
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h0300;
    startIssues = issueCount;
    repeat (5) @(negedge clk);
    memLat = 1;
    issueQ.push_back('{1'b0, 16'h0200, 16'h0000});
    dmRespQ.push_back(rdataFor(16'h0200));
    dmModel = rdataFor(16'h0200);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200; dm_wdata = 16'h0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (dm_done === 1'b1) seen = 1'b1;
    end
    dm_req = 1'b0;
    checkOutput("halt_dm_served", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("halt_if_stall", 32'(if_stall), 32'd1);
    checkOutput("halt_issue_count", 32'(issueCount - startIssues), 32'd1);
    if_req = 1'b0; halt = 1'b0;

    $display("[TB] halt raised while a fetch is waiting");
    @(negedge clk);
    memLat = 4;
    issueQ.push_back('{1'b0, 16'h0040, 16'h0000});
    ifRespQ.push_back(16'h1234);
    if_req = 1'b1; if_addr = 16'h0040;
    cyc = 0;
    while (mem_en !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    halt = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (if_done === 1'b1) seen = 1'b1;
    end
    checkOutput("halt_wait_if_done", 32'(seen), 32'd1);
    if_req = 1'b0; halt = 1'b0;

    $display("[TB] mem_busy holds off the issue");
    @(negedge clk);
    memLat = 1;
    mem_busy = 1'b1;
    issueQ.push_back('{1'b0, 16'h0400, 16'h0000});
    dmRespQ.push_back(rdataFor(16'h0400));
    dmModel = rdataFor(16'h0400);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0400; dm_wdata = 16'h0;
    startIssues = issueCount;
    repeat (3) @(negedge clk);
    checkOutput("busy_no_issue", 32'(issueCount - startIssues), 32'd0);
    mem_busy = 1'b0;
    fallCycle = cycleCnt;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dm_done === 1'b1) seen = 1'b1;
    end
    dm_req = 1'b0;
    checkOutput("busy_dm_done", 32'(seen), 32'd1);
    checkOutput("busy_issue_cycle", 32'(lastIssueCycle - fallCycle), 32'd1);

    $display("[TB] reset during WAIT with a stale completion");
    @(negedge clk);
    memLat = 5;
    issueQ.push_back('{1'b0, 16'h0500, 16'h0000});
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500; dm_wdata = 16'h0;
    cyc = 0;
    while (mem_en !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_if_done", 32'(if_done), 32'd0);
    checkOutput("rst_dm_done", 32'(dm_done), 32'd0);
    checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
    checkOutput("rst_dm_rdata", 32'(dm_rdata), 32'd0);
    checkOutput("rst_dm_stall", 32'(dm_stall), 32'd0);
    startDones  = ifDoneCount + dmDoneCount;
    startIssues = issueCount;
    repeat (8) @(negedge clk);
    checkOutput("rst_stray_no_done", 32'(ifDoneCount + dmDoneCount - startDones), 32'd0);
    checkOutput("rst_stray_no_issue", 32'(issueCount - startIssues), 32'd0);

    checkOutput("final_issueQ_empty", 32'(issueQ.size()), 32'd0);
    checkOutput("final_ifRespQ_empty", 32'(ifRespQ.size()), 32'd0);
    checkOutput("final_dmRespQ_empty", 32'(dmRespQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
